// File: rtl/manchester_pkg.sv
// Shared types and line-level constants for the Manchester transmit scheduler.
package manchester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_DATA = 3'd3,
    ST_PAR  = 3'd4,
    ST_GAP  = 3'd5
  } state_t;

  localparam logic [7:0] SFD_DEFAULT = 8'hD5;

  // Line is parked low whenever no symbol is being sent.
  localparam logic LINE_IDLE = 1'b0;

  // IEEE 802.3 convention: '1' is low->high, '0' is high->low, so the first
  // half carries the complement of the bit and the second half the bit.
  function automatic logic line_level(input logic bit_val, input logic second_half);
    return second_half ? bit_val : ~bit_val;
  endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// Half-bit prescaler: a down-counter reloaded every HALF_DIV cycles, a half
// selector toggled at each terminal count, and a bit tick on the last cycle of
// the second half. Held at its load value while disabled.
module manchester_bit_timer #(
  parameter int HALF_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic half_sel,
  output logic bit_tick,
  output logic bit_first
);

  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] LOAD = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          half_q;
  logic          half_tc;

  assign half_tc   = (cnt_q == '0);
  assign half_sel  = half_q;
  assign bit_tick  = en & half_q & half_tc;
  assign bit_first = en & ~half_q & (cnt_q == LOAD);

  // Count down through each half; flip the half selector at terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= LOAD;
      half_q <= 1'b0;
    end else if (!en) begin
      cnt_q  <= LOAD;
      half_q <= 1'b0;
    end else if (half_tc) begin
      cnt_q  <= LOAD;
      half_q <= ~half_q;
    end else begin
      cnt_q  <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/manchester_tx_sched.sv
// Round-robin scheduler sharing one Manchester line between two byte
// requesters. Each grant sends preamble, SFD, payload (MSB first), an optional
// even-parity bit, then an idle gap with the line still driven.
// Optional feature macro: MANCH_TX_PARITY_EN (adds the PAR state).
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | line released; arbitrate and accept one request
//   ST_PRE  | PRE_BITS preamble bits, 1,0,1,0... starting with 1
//   ST_SFD  | 8-bit start-of-frame delimiter, MSB first
//   ST_DATA | 8 payload bits, MSB first
//   ST_PAR  | one even-parity bit over the payload (parity build only)
//   ST_GAP  | IFG_BITS bit periods of low line with tx_oe still high
module manchester_tx_sched
  import manchester_pkg::*;
#(
  parameter int         HALF_DIV = 4,
  parameter int         PRE_BITS = 8,
  parameter logic [7:0] SFD      = SFD_DEFAULT,
  parameter int         IFG_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic       tx_out,
  output logic       tx_oe,
  output logic       busy,
  output logic       grant_id,
  output logic       done
);

  localparam int MAX_BITS = (PRE_BITS > IFG_BITS) ? ((PRE_BITS > 8) ? PRE_BITS : 8)
                                                  : ((IFG_BITS > 8) ? IFG_BITS : 8);
  localparam int BW = $clog2(MAX_BITS);
  localparam logic [BW-1:0] PRE_LOAD  = BW'(PRE_BITS - 1);
  localparam logic [BW-1:0] BYTE_LOAD = BW'(7);
  localparam logic [BW-1:0] GAP_LOAD  = BW'(IFG_BITS - 1);

  state_t        state_q, state_d;
  logic          ptr_q, grant_q, pre_bit_q;
  logic [7:0]    data_q, sh_q;
  logic [BW-1:0] bidx_q, bidx_load;
  logic          half_sel, bit_tick, bit_first;
  logic          accept, win, last_bit, par_bit, cur_bit, field_start;

  manchester_bit_timer #(.HALF_DIV(HALF_DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .half_sel  (half_sel),
    .bit_tick  (bit_tick),
    .bit_first (bit_first)
  );

  // Pointer side wins if it is asking, otherwise the other side.
  assign win         = req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign accept      = (state_q == ST_IDLE) && ena && (req_valid != 2'b00);
  assign req_ready   = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign last_bit    = (bidx_q == '0);
  assign field_start = (state_d != state_q);
  assign busy        = (state_q != ST_IDLE);
  assign tx_oe       = busy;
  assign grant_id    = grant_q;
  assign done        = (state_q == ST_GAP) && bit_first && (bidx_q == GAP_LOAD);

`ifdef MANCH_TX_PARITY_EN
  assign par_bit = ^data_q;
`else
  assign par_bit = 1'b0;
`endif

  // Next state and the bit-index reload value for the field being entered.
  always_comb begin
    state_d   = state_q;
    bidx_load = '0;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_PRE;
      ST_PRE:  if (bit_tick && last_bit) state_d = ST_SFD;
      ST_SFD:  if (bit_tick && last_bit) state_d = ST_DATA;
`ifdef MANCH_TX_PARITY_EN
      ST_DATA: if (bit_tick && last_bit) state_d = ST_PAR;
`else
      ST_DATA: if (bit_tick && last_bit) state_d = ST_GAP;
`endif
      ST_PAR:  if (bit_tick) state_d = ST_GAP;
      ST_GAP:  if (bit_tick && last_bit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    case (state_d)
      ST_PRE:           bidx_load = PRE_LOAD;
      ST_SFD, ST_DATA:  bidx_load = BYTE_LOAD;
      ST_GAP:           bidx_load = GAP_LOAD;
      default:          bidx_load = '0;
    endcase
  end

  // Line level: complement of the current bit in the first half, bit in the second.
  always_comb begin
    cur_bit = 1'b0;
    tx_out  = LINE_IDLE;
    case (state_q)
      ST_PRE:          cur_bit = pre_bit_q;
      ST_SFD, ST_DATA: cur_bit = sh_q[7];
      ST_PAR:          cur_bit = par_bit;
      default:         cur_bit = 1'b0;
    endcase
    if (state_q inside {ST_PRE, ST_SFD, ST_DATA, ST_PAR})
      tx_out = line_level(cur_bit, half_sel);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Arbiter: latch payload and owner on acceptance, hand priority to the loser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
      data_q  <= '0;
    end else if (accept) begin
      ptr_q   <= ~win;
      grant_q <= win;
      data_q  <= win ? req_data1 : req_data0;
    end
  end

  // Serial datapath: bit index down-counter, MSB-first shifter, preamble toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bidx_q    <= '0;
      sh_q      <= '0;
      pre_bit_q <= 1'b0;
    end else begin
      if (field_start)   bidx_q <= bidx_load;
      else if (bit_tick) bidx_q <= bidx_q - BW'(1);

      if (state_d == ST_SFD && state_q != ST_SFD)        sh_q <= SFD;
      else if (state_d == ST_DATA && state_q != ST_DATA) sh_q <= data_q;
      else if (bit_tick)                                 sh_q <= {sh_q[6:0], 1'b0};

      if (accept)        pre_bit_q <= 1'b1;
      else if (bit_tick) pre_bit_q <= ~pre_bit_q;
    end
  end

endmodule
